cpu_6502_core: RTL and testbench
================================

// Module: cpu_6502_core
// PURPOSE
//  Minimal 6502-compatible CPU core: load/store subset (LDA/LDX/LDY/STA/STX/STY).
//  Drives a flat 64 KiB memory over a single 8-bit data bus; top-level CPU of the system.
//  The memory returns read data combinationally from ab and writes do at the posedge where we=1.
// PARAMETERS
//  RESET_PC  16'h0000  PC loaded on reset; no reset-vector fetch.
// PORTS
//  clk    in   1   single system clock, all state on posedge
//  reset  in   1   asynchronous, active-high reset
//  di     in   8   read data from memory at ab; valid in the same cycle when we=0
//  do     out  8   write data; valid while we=1
//  we     out  1   write enable; memory writes do to ab at the posedge ending the cycle
//  ab     out  16  address bus
// BEHAVIOUR
//  - Reset (async, active-high): PC=RESET_PC, A=X=Y=0, N=Z=0, ab=RESET_PC, do=0, we=0, state=T0.
//  - ab, do and we are registered; each cycle Tn presents them, and the edge ending Tn consumes di.
//  - T0: ab=PC; opcode latched, PC++.
//  - T1: ab=PC; operand low byte (or immediate) latched, PC++.
//  - Immediate (2 cyc): value loaded at end of T1. Opcodes A9 LDA, A2 LDX, A0 LDY.
//  - Zero page (3 cyc): T2 ab={8'h00,op}.
//    Loads A5 LDA, A6 LDX, A4 LDY latch di. Stores 85 STA, 86 STX, 84 STY drive we=1, do=reg.
//  - Absolute (4 cyc): T2 ab=PC, hi byte latched, PC++. T3 ab={hi,lo} for read or write.
//    Loads AD, AE, AC. Stores 8D, 8E, 8C.
//  - Indexed load (4 cyc, no page-cross penalty): T3 ab={hi,lo}+index, 16-bit add, wraps at FFFF.
//    BD LDA,X; B9 LDA,Y; BE LDX,Y; BC LDY,X.
//  - Indexed store (5 cyc): T3 dummy read, we=0, ab={hi,lo+idx[7:0]} (no carry).
//    T4 write, we=1, ab={hi,lo}+idx. Opcodes 9D STA,X and 99 STA,Y.
//  - Loads set Z=(val==0) and N=val[7]; stores leave flags unchanged.
//  - we=1 only in the final cycle of a store; otherwise we=0 and do holds its last value.
//  - Any other opcode: 1-byte, 2-cycle NOP. T1 reads PC without incrementing it; no state changes.
//  - PC wraps FFFF->0000.
//  - Reset mid-instruction aborts immediately; a pending write is never issued.
// STRUCTURE
//  - Shared package cpu6502_pkg: opcode localparams, addressing-mode enum (IMM, ZP, ABS, ABX, ABY, NOP).
//    Also the state enum (T0..T4).
//  - One sub-module, cpu6502_decode: combinational, opcode -> {mode, dst/src reg, is_store}.
//  - Top holds the registers A/X/Y/PC/N/Z, the operand latches and the cycle FSM.
// TESTING (clk period 10; memory zero-filled; reset pulse; PC=0)
//  - A2 05 A0 0B BD 07 05 99 10 05, mem[050C]=0x16 -> mem[051B]=0x16 after 13 cycles.
//    The write cycle has ab=051B, we=1, do=0x16; mem[050C] is unchanged.
//  - A9 27 8D 11 00 A2 21 8E 16 00 A0 47 8C 17 00 -> mem[0011]=0x27, mem[0016]=0x21, mem[0017]=0x47.
//    Total 18 cycles; then opcode 03 runs as a NOP.
//  - AE 00 04 8E 40 04 A5 30 85 35, mem[0400]=90, mem[0030]=71 -> mem[0440]=90, mem[0035]=71.
//    The ZP store has ab=0035.
//  - Flags: A9 00 -> Z=1 N=0; A9 80 -> Z=0 N=1; a following STA leaves the flags unchanged.
//  - Index wrap: X=FF, BD 10 05 -> reads 060F.
//    Y=F0, 99 20 05 -> dummy read at 0510, then write at 0610.
//  - Assert reset during T3 of 8D -> we stays 0, no write; after release ab=0000 and the opcode is refetched.

Source files
------------

// File: rtl/cpu6502_pkg.sv
// Shared types for the 6502 load/store core: opcodes, addressing modes,
// register selects and the per-instruction cycle states.
package cpu6502_pkg;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
    localparam logic [7:0] OP_LDX_ZP  = 8'hA6;
    localparam logic [7:0] OP_LDY_ZP  = 8'hA4;
    localparam logic [7:0] OP_STA_ZP  = 8'h85;
    localparam logic [7:0] OP_STX_ZP  = 8'h86;
    localparam logic [7:0] OP_STY_ZP  = 8'h84;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_LDX_ABS = 8'hAE;
    localparam logic [7:0] OP_LDY_ABS = 8'hAC;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_STX_ABS = 8'h8E;
    localparam logic [7:0] OP_STY_ABS = 8'h8C;
    localparam logic [7:0] OP_LDA_ABX = 8'hBD;
    localparam logic [7:0] OP_LDA_ABY = 8'hB9;
    localparam logic [7:0] OP_LDX_ABY = 8'hBE;
    localparam logic [7:0] OP_LDY_ABX = 8'hBC;
    localparam logic [7:0] OP_STA_ABX = 8'h9D;
    localparam logic [7:0] OP_STA_ABY = 8'h99;

    typedef enum logic [2:0] {
        MODE_IMM,
        MODE_ZP,
        MODE_ABS,
        MODE_ABX,
        MODE_ABY,
        MODE_NOP
    } addr_mode_t;

    typedef enum logic [1:0] {
        SEL_A,
        SEL_X,
        SEL_Y
    } reg_sel_t;

    typedef enum logic [2:0] {
        T0,
        T1,
        T2,
        T3,
        T4
    } cpu_state_t;

    // Modes that fetch a 16-bit operand and access memory in T3.
    function automatic logic is_abs_family(addr_mode_t m);
        return (m == MODE_ABS) || (m == MODE_ABX) || (m == MODE_ABY);
    endfunction

endpackage

// File: rtl/cpu6502_decode.sv
// Opcode decoder: maps an opcode to its addressing mode, the register it
// loads or stores, and whether it writes memory. Unknown opcodes decode as NOP.
module cpu6502_decode
    import cpu6502_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [2:0] mode,
    output logic [1:0] sel,
    output logic       is_store
);

    always_comb begin
        mode     = MODE_NOP;
        sel      = SEL_A;
        is_store = 1'b0;
        case (opcode)
            OP_LDA_IMM: begin mode = MODE_IMM; sel = SEL_A; end
            OP_LDX_IMM: begin mode = MODE_IMM; sel = SEL_X; end
            OP_LDY_IMM: begin mode = MODE_IMM; sel = SEL_Y; end
            OP_LDA_ZP:  begin mode = MODE_ZP;  sel = SEL_A; end
            OP_LDX_ZP:  begin mode = MODE_ZP;  sel = SEL_X; end
            OP_LDY_ZP:  begin mode = MODE_ZP;  sel = SEL_Y; end
            OP_STA_ZP:  begin mode = MODE_ZP;  sel = SEL_A; is_store = 1'b1; end
            OP_STX_ZP:  begin mode = MODE_ZP;  sel = SEL_X; is_store = 1'b1; end
            OP_STY_ZP:  begin mode = MODE_ZP;  sel = SEL_Y; is_store = 1'b1; end
            OP_LDA_ABS: begin mode = MODE_ABS; sel = SEL_A; end
            OP_LDX_ABS: begin mode = MODE_ABS; sel = SEL_X; end
            OP_LDY_ABS: begin mode = MODE_ABS; sel = SEL_Y; end
            OP_STA_ABS: begin mode = MODE_ABS; sel = SEL_A; is_store = 1'b1; end
            OP_STX_ABS: begin mode = MODE_ABS; sel = SEL_X; is_store = 1'b1; end
            OP_STY_ABS: begin mode = MODE_ABS; sel = SEL_Y; is_store = 1'b1; end
            OP_LDA_ABX: begin mode = MODE_ABX; sel = SEL_A; end
            OP_LDA_ABY: begin mode = MODE_ABY; sel = SEL_A; end
            OP_LDX_ABY: begin mode = MODE_ABY; sel = SEL_X; end
            OP_LDY_ABX: begin mode = MODE_ABX; sel = SEL_Y; end
            OP_STA_ABX: begin mode = MODE_ABX; sel = SEL_A; is_store = 1'b1; end
            OP_STA_ABY: begin mode = MODE_ABY; sel = SEL_A; is_store = 1'b1; end
            default:    begin mode = MODE_NOP; sel = SEL_A; end
        endcase
    end

endmodule

// File: rtl/cpu_6502_core.sv
// Minimal 6502-compatible core executing the LDA/LDX/LDY/STA/STX/STY subset.
// Bus outputs are registered: each edge computes the address/strobe for the next cycle.
module cpu_6502_core
    import cpu6502_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  di,
    output logic [7:0]  dout,
    output logic        we,
    output logic [15:0] ab
);

    cpu_state_t  state_reg;
    logic [15:0] pc_reg;
    logic [7:0]  a_reg;
    logic [7:0]  x_reg;
    logic [7:0]  y_reg;
    logic        n_reg;
    logic        z_reg;
    logic [7:0]  opcode_reg;
    logic [7:0]  lo_reg;
    logic [7:0]  hi_reg;

    logic [2:0]  mode_bits;
    logic [1:0]  sel_bits;
    logic        is_store;
    addr_mode_t  mode;
    reg_sel_t    sel;

    logic [15:0] pc_inc;
    logic [7:0]  src_val;
    logic [7:0]  idx_val;
    logic [7:0]  lo_idx;
    logic [15:0] t2_eff;
    logic [15:0] t3_eff;
    logic        load_en;

    cpu6502_decode u_decode (
        .opcode   (opcode_reg),
        .mode     (mode_bits),
        .sel      (sel_bits),
        .is_store (is_store)
    );

    assign mode = addr_mode_t'(mode_bits);
    assign sel  = reg_sel_t'(sel_bits);

    always_comb begin
        pc_inc  = pc_reg + 16'd1;
        src_val = a_reg;
        case (sel)
            SEL_X:   src_val = x_reg;
            SEL_Y:   src_val = y_reg;
            default: src_val = a_reg;
        endcase
        idx_val = (mode == MODE_ABX) ? x_reg : y_reg;
        // Indexed stores first probe the un-carried address, as real silicon does.
        lo_idx  = lo_reg + idx_val;
        t2_eff  = {di, lo_reg} + {8'h00, idx_val};
        t3_eff  = {hi_reg, lo_reg} + {8'h00, idx_val};
        case (state_reg)
            T1:      load_en = (mode == MODE_IMM);
            T2:      load_en = (mode == MODE_ZP) && !is_store;
            T3:      load_en = is_abs_family(mode) && !is_store;
            default: load_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= T0;
            pc_reg     <= RESET_PC;
            a_reg      <= 8'h00;
            x_reg      <= 8'h00;
            y_reg      <= 8'h00;
            n_reg      <= 1'b0;
            z_reg      <= 1'b0;
            opcode_reg <= 8'h00;
            lo_reg     <= 8'h00;
            hi_reg     <= 8'h00;
            ab         <= RESET_PC;
            dout       <= 8'h00;
            we         <= 1'b0;
        end else begin
            we <= 1'b0;

            if (load_en) begin
                case (sel)
                    SEL_A:   a_reg <= di;
                    SEL_X:   x_reg <= di;
                    SEL_Y:   y_reg <= di;
                    default: ;
                endcase
                n_reg <= di[7];
                z_reg <= (di == 8'h00);
            end

            case (state_reg)
                T0: begin
                    opcode_reg <= di;
                    pc_reg     <= pc_inc;
                    ab         <= pc_inc;
                    state_reg  <= T1;
                end
                T1: begin
                    case (mode)
                        MODE_NOP: begin
                            ab        <= pc_reg;
                            state_reg <= T0;
                        end
                        MODE_IMM: begin
                            pc_reg    <= pc_inc;
                            ab        <= pc_inc;
                            state_reg <= T0;
                        end
                        MODE_ZP: begin
                            lo_reg    <= di;
                            pc_reg    <= pc_inc;
                            ab        <= {8'h00, di};
                            we        <= is_store;
                            if (is_store) begin
                                dout <= src_val;
                            end
                            state_reg <= T2;
                        end
                        default: begin
                            lo_reg    <= di;
                            pc_reg    <= pc_inc;
                            ab        <= pc_inc;
                            state_reg <= T2;
                        end
                    endcase
                end
                T2: begin
                    if (mode == MODE_ZP) begin
                        ab        <= pc_reg;
                        state_reg <= T0;
                    end else begin
                        hi_reg    <= di;
                        pc_reg    <= pc_inc;
                        state_reg <= T3;
                        if (mode == MODE_ABS) begin
                            ab <= {di, lo_reg};
                            we <= is_store;
                            if (is_store) begin
                                dout <= src_val;
                            end
                        end else if (is_store) begin
                            ab <= {di, lo_idx};
                        end else begin
                            ab <= t2_eff;
                        end
                    end
                end
                T3: begin
                    if ((mode != MODE_ABS) && is_store) begin
                        ab        <= t3_eff;
                        we        <= 1'b1;
                        dout      <= src_val;
                        state_reg <= T4;
                    end else begin
                        ab        <= pc_reg;
                        state_reg <= T0;
                    end
                end
                T4: begin
                    ab        <= pc_reg;
                    state_reg <= T0;
                end
                default: begin
                    ab        <= pc_reg;
                    state_reg <= T0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_6502_core.sv
// Bench for cpu_6502_core: flat memory model, table of single-load vectors,
// and bus-trace sequences checked against a queue of expected cycles.
module tb_cpu_6502_core;

    logic        clk;
    logic        reset;
    logic [7:0]  di;
    logic [7:0]  dout;
    logic        we;
    logic [15:0] ab;

    logic [7:0]  mem [0:65535];
    logic [7:0]  prog [$];

    typedef struct {
        logic [15:0] ab;
        logic        we;
        logic [7:0]  dout;
    } bus_t;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [15:0] data_addr;
        logic [7:0]  data_val;
        int          cycles;
        int          len;
        int          sel;
        logic [7:0]  exp_val;
        logic        exp_n;
        logic        exp_z;
    } vec_t;

    bus_t exp_q [$];
    vec_t vecs [13];
    int   compared;
    int   mismatched;

    cpu_6502_core #(.RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .di    (di),
        .dout  (dout),
        .we    (we),
        .ab    (ab)
    );

    assign di = mem[ab];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic expect_bus(input logic [15:0] a, input logic w = 1'b0, input logic [7:0] d = 8'h00);
        bus_t e;
        e.ab = a;
        e.we = w;
        e.dout = d;
        exp_q.push_back(e);
    endtask

    task automatic check_bus();
        bus_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (ab !== e.ab || we !== e.we || (e.we && dout !== e.dout)) begin
                mismatched++;
                $display("FAIL bus @%0t: ab=%h we=%b do=%h, required ab=%h we=%b do=%h",
                         $time, ab, we, dout, e.ab, e.we, e.dout);
            end
        end
    endtask

    // One bus cycle: compare at the negedge, then commit any write at the posedge.
    task automatic run_cycles(input int n);
        logic [15:0] ca;
        logic        cw;
        logic [7:0]  cd;
        for (int i = 0; i < n; i++) begin
            check_bus();
            ca = ab;
            cw = we;
            cd = dout;
            @(posedge clk);
            if (cw) mem[ca] = cd;
            @(negedge clk);
        end
    endtask

    task automatic begin_test();
        reset = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 65536; k++) mem[k] = 8'h00;
    endtask

    task automatic load_prog();
        foreach (prog[k]) mem[k] = prog[k];
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [7:0] reg_val(input int sel);
        case (sel)
            1:       return dut.x_reg;
            2:       return dut.y_reg;
            default: return dut.a_reg;
        endcase
    endfunction

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;

        //        op     b1     b2     addr      val    cyc len sel exp    n     z
        vecs[0]  = '{8'hA9, 8'h27, 8'h00, 16'h0000, 8'h00, 2, 2, 0, 8'h27, 1'b0, 1'b0};
        vecs[1]  = '{8'hA9, 8'h00, 8'h00, 16'h0000, 8'h00, 2, 2, 0, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{8'hA9, 8'h80, 8'h00, 16'h0000, 8'h00, 2, 2, 0, 8'h80, 1'b1, 1'b0};
        vecs[3]  = '{8'hA2, 8'h21, 8'h00, 16'h0000, 8'h00, 2, 2, 1, 8'h21, 1'b0, 1'b0};
        vecs[4]  = '{8'hA0, 8'h47, 8'h00, 16'h0000, 8'h00, 2, 2, 2, 8'h47, 1'b0, 1'b0};
        vecs[5]  = '{8'hA5, 8'h30, 8'h00, 16'h0030, 8'h71, 3, 2, 0, 8'h71, 1'b0, 1'b0};
        vecs[6]  = '{8'hA6, 8'h30, 8'h00, 16'h0030, 8'hFE, 3, 2, 1, 8'hFE, 1'b1, 1'b0};
        vecs[7]  = '{8'hA4, 8'h30, 8'h00, 16'h0030, 8'h00, 3, 2, 2, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{8'hAD, 8'h00, 8'h04, 16'h0400, 8'h90, 4, 3, 0, 8'h90, 1'b1, 1'b0};
        vecs[9]  = '{8'hAE, 8'h34, 8'h12, 16'h1234, 8'h05, 4, 3, 1, 8'h05, 1'b0, 1'b0};
        vecs[10] = '{8'hAC, 8'hFF, 8'hFF, 16'hFFFF, 8'h42, 4, 3, 2, 8'h42, 1'b0, 1'b0};
        vecs[11] = '{8'hBD, 8'h07, 8'h05, 16'h0507, 8'h33, 4, 3, 0, 8'h33, 1'b0, 1'b0};
        vecs[12] = '{8'h03, 8'h00, 8'h00, 16'h0000, 8'h00, 2, 1, 0, 8'h00, 1'b0, 1'b0};

        // Single-instruction loads from the table.
        for (int i = 0; i < 13; i++) begin
            begin_test();
            mem[vecs[i].data_addr] = vecs[i].data_val;
            mem[0] = vecs[i].op;
            mem[1] = vecs[i].b1;
            mem[2] = vecs[i].b2;
            expect_bus(16'h0000);
            expect_bus(16'h0001);
            if (vecs[i].cycles == 3) expect_bus(vecs[i].data_addr);
            if (vecs[i].cycles == 4) begin
                expect_bus(16'h0002);
                expect_bus(vecs[i].data_addr);
            end
            expect_bus(16'(vecs[i].len));
            release_reset();
            run_cycles(vecs[i].cycles + 1);
            check($sformatf("vec%0d_queue_left", i), 16'(exp_q.size()), 16'd0);
            check($sformatf("vec%0d_reg", i), {8'h00, reg_val(vecs[i].sel)}, {8'h00, vecs[i].exp_val});
            check($sformatf("vec%0d_n", i), {15'd0, dut.n_reg}, {15'd0, vecs[i].exp_n});
            check($sformatf("vec%0d_z", i), {15'd0, dut.z_reg}, {15'd0, vecs[i].exp_z});
        end

        // LDX#/LDY#/LDA abs,X/STA abs,Y: 13 cycles ending in the write to 051B.
        begin_test();
        prog = '{8'hA2, 8'h05, 8'hA0, 8'h0B, 8'hBD, 8'h07, 8'h05, 8'h99, 8'h10, 8'h05};
        load_prog();
        mem[16'h050C] = 8'h16;
        expect_bus(16'h0000); expect_bus(16'h0001);
        expect_bus(16'h0002); expect_bus(16'h0003);
        expect_bus(16'h0004); expect_bus(16'h0005); expect_bus(16'h0006); expect_bus(16'h050C);
        expect_bus(16'h0007); expect_bus(16'h0008); expect_bus(16'h0009);
        expect_bus(16'h051B); expect_bus(16'h051B, 1'b1, 8'h16);
        expect_bus(16'h000A);
        release_reset();
        run_cycles(14);
        check("seq1_queue_left", 16'(exp_q.size()), 16'd0);
        check("seq1_mem051B", {8'h00, mem[16'h051B]}, 16'h0016);
        check("seq1_mem050C", {8'h00, mem[16'h050C]}, 16'h0016);

        // Three absolute stores (18 cycles) followed by an unknown opcode NOP.
        begin_test();
        prog = '{8'hA9, 8'h27, 8'h8D, 8'h11, 8'h00, 8'hA2, 8'h21, 8'h8E, 8'h16, 8'h00,
                 8'hA0, 8'h47, 8'h8C, 8'h17, 8'h00, 8'h03};
        load_prog();
        expect_bus(16'h0000); expect_bus(16'h0001);
        expect_bus(16'h0002); expect_bus(16'h0003); expect_bus(16'h0004);
        expect_bus(16'h0011, 1'b1, 8'h27);
        expect_bus(16'h0005); expect_bus(16'h0006);
        expect_bus(16'h0007); expect_bus(16'h0008); expect_bus(16'h0009);
        expect_bus(16'h0016, 1'b1, 8'h21);
        expect_bus(16'h000A); expect_bus(16'h000B);
        expect_bus(16'h000C); expect_bus(16'h000D); expect_bus(16'h000E);
        expect_bus(16'h0017, 1'b1, 8'h47);
        expect_bus(16'h000F); expect_bus(16'h0010); expect_bus(16'h0010);
        release_reset();
        run_cycles(21);
        check("seq2_queue_left", 16'(exp_q.size()), 16'd0);
        check("seq2_mem0011", {8'h00, mem[16'h0011]}, 16'h0027);
        check("seq2_mem0016", {8'h00, mem[16'h0016]}, 16'h0021);
        check("seq2_mem0017", {8'h00, mem[16'h0017]}, 16'h0047);
        check("seq2_a_after_nop", {8'h00, dut.a_reg}, 16'h0027);

        // Absolute and zero-page load/store round trip.
        begin_test();
        prog = '{8'hAE, 8'h00, 8'h04, 8'h8E, 8'h40, 8'h04, 8'hA5, 8'h30, 8'h85, 8'h35};
        load_prog();
        mem[16'h0400] = 8'h90;
        mem[16'h0030] = 8'h71;
        expect_bus(16'h0000); expect_bus(16'h0001); expect_bus(16'h0002); expect_bus(16'h0400);
        expect_bus(16'h0003); expect_bus(16'h0004); expect_bus(16'h0005);
        expect_bus(16'h0440, 1'b1, 8'h90);
        expect_bus(16'h0006); expect_bus(16'h0007); expect_bus(16'h0030);
        expect_bus(16'h0008); expect_bus(16'h0009);
        expect_bus(16'h0035, 1'b1, 8'h71);
        expect_bus(16'h000A);
        release_reset();
        run_cycles(15);
        check("seq3_queue_left", 16'(exp_q.size()), 16'd0);
        check("seq3_mem0440", {8'h00, mem[16'h0440]}, 16'h0090);
        check("seq3_mem0035", {8'h00, mem[16'h0035]}, 16'h0071);

        // Flags follow loads and survive stores.
        begin_test();
        prog = '{8'hA9, 8'h00, 8'h85, 8'h50, 8'hA9, 8'h80, 8'h8D, 8'h60, 8'h00};
        load_prog();
        release_reset();
        run_cycles(2);
        check("flags_lda00_z", {15'd0, dut.z_reg}, 16'd1);
        check("flags_lda00_n", {15'd0, dut.n_reg}, 16'd0);
        run_cycles(3);
        check("flags_sta_zp_z", {15'd0, dut.z_reg}, 16'd1);
        check("flags_sta_zp_n", {15'd0, dut.n_reg}, 16'd0);
        run_cycles(2);
        check("flags_lda80_z", {15'd0, dut.z_reg}, 16'd0);
        check("flags_lda80_n", {15'd0, dut.n_reg}, 16'd1);
        run_cycles(4);
        check("flags_sta_abs_z", {15'd0, dut.z_reg}, 16'd0);
        check("flags_sta_abs_n", {15'd0, dut.n_reg}, 16'd1);
        check("flags_mem0060", {8'h00, mem[16'h0060]}, 16'h0080);

        // Index carry into the high byte; indexed store dummy read has no carry.
        begin_test();
        prog = '{8'hA2, 8'hFF, 8'hBD, 8'h10, 8'h05, 8'hA0, 8'hF0, 8'h99, 8'h20, 8'h05};
        load_prog();
        mem[16'h060F] = 8'h5A;
        expect_bus(16'h0000); expect_bus(16'h0001);
        expect_bus(16'h0002); expect_bus(16'h0003); expect_bus(16'h0004); expect_bus(16'h060F);
        expect_bus(16'h0005); expect_bus(16'h0006);
        expect_bus(16'h0007); expect_bus(16'h0008); expect_bus(16'h0009);
        expect_bus(16'h0510); expect_bus(16'h0610, 1'b1, 8'h5A);
        expect_bus(16'h000A);
        release_reset();
        run_cycles(14);
        check("wrap_queue_left", 16'(exp_q.size()), 16'd0);
        check("wrap_mem0610", {8'h00, mem[16'h0610]}, 16'h005A);
        check("wrap_mem0510", {8'h00, mem[16'h0510]}, 16'h0000);

        // Reset during the write cycle of STA abs aborts the write.
        begin_test();
        prog = '{8'hA9, 8'h3C, 8'h8D, 8'h11, 8'h00};
        load_prog();
        expect_bus(16'h0000); expect_bus(16'h0001);
        expect_bus(16'h0002); expect_bus(16'h0003); expect_bus(16'h0004);
        expect_bus(16'h0011, 1'b1, 8'h3C);
        release_reset();
        run_cycles(5);
        check_bus();
        reset = 1'b1;
        #1;
        check("rst_we", {15'd0, we}, 16'd0);
        check("rst_ab", ab, 16'h0000);
        check("rst_do", {8'h00, dout}, 16'h0000);
        check("rst_a", {8'h00, dut.a_reg}, 16'h0000);
        @(negedge clk);
        run_cycles(2);
        check("rst_no_write", {8'h00, mem[16'h0011]}, 16'h0000);
        expect_bus(16'h0000); expect_bus(16'h0001); expect_bus(16'h0002);
        reset = 1'b0;
        run_cycles(3);
        check("rst_queue_left", 16'(exp_q.size()), 16'd0);
        check("rst_refetch_a", {8'h00, dut.a_reg}, 16'h003C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
